// File: rtl/attn_seq_pkg.sv
// Shared definitions for the attention instruction sequencer:
// inst bit positions, FSM state encoding and normalization sub-steps.
package attn_seq_pkg;

    localparam int INST_W        = 20;
    localparam int B_SFP_PMEM_WR = 19;
    localparam int B_ACC         = 18;
    localparam int B_DIV         = 17;
    localparam int B_OFIFO_RD    = 16;
    localparam int B_QKMEM_ADD   = 12;
    localparam int B_PMEM_ADD    = 8;
    localparam int B_EXECUTE     = 7;
    localparam int B_LOAD        = 6;
    localparam int B_QMEM_RD     = 5;
    localparam int B_QMEM_WR     = 4;
    localparam int B_KMEM_RD     = 3;
    localparam int B_KMEM_WR     = 2;
    localparam int B_PMEM_RD     = 1;
    localparam int B_PMEM_WR     = 0;
    localparam int ADD_FIELD_W   = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_QWR,
        ST_KWR,
        ST_GAP,
        ST_LOAD,
        ST_SETTLE1,
        ST_EXEC,
        ST_SETTLE2,
        ST_OFIFO,
        ST_NORM,
        ST_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        NS_ACC,
        NS_WAIT,
        NS_DIV,
        NS_WB
    } norm_step_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
// Loading N gives a phase of N+1 cycles ending on the tc cycle.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/attn_inst_sequencer.sv
// Drives fullchip inst/mem_in through one attention pass (Q/K write, load,
// execute, OFIFO->PMEM, optional normalization). i_reset is active-low.
//
// state    | meaning
// IDLE     | waiting for start, rejects illegal nq
// QWR/KWR  | host Q / K vectors written into qmem / kmem
// GAP      | idle gap after K write
// LOAD     | kmem read into the array, load held high
// SETTLE1/2| idle settle after load / after execute
// EXEC     | one execute per Q vector
// OFIFO    | ofifo rows moved into pmem
// NORM     | ACC, WAIT, DIV, WB per pmem row
// DONE     | one-cycle done pulse
module attn_inst_sequencer #(
    parameter int BW         = 8,
    parameter int PR         = 8,
    parameter int COL        = 8,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYC    = 2,
    parameter int SETTLE_CYC = 10
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [ADDR_W:0]    i_nq,
    input  logic               i_norm_en,
    input  logic               i_abort,
    input  logic               i_in_valid,
    input  logic [PR*BW-1:0]   i_in_data,
    output logic               o_in_ready,
    output logic [PR*BW-1:0]   o_mem_in,
    output logic [19:0]        o_inst,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    import attn_seq_pkg::*;

    localparam int NQ_W    = ADDR_W + 1;
    localparam int IDX_W   = $clog2(COL + (1 << ADDR_W) + 3);
    localparam int TMR_MAX = (SETTLE_CYC > COL + 2) ?
                             ((SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC) :
                             ((COL + 2 > GAP_CYC) ? COL + 2 : GAP_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    seq_state_t          r_state, w_state_nx;
    norm_step_t          r_step, w_step_nx;
    logic [IDX_W-1:0]    r_idx, w_idx_nx;
    logic [NQ_W-1:0]     r_nq;
    logic                r_norm_en;
    logic [INST_W-1:0]   r_inst, w_inst;
    logic [PR*BW-1:0]    r_mem_in, w_mem_in;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_err, w_err;
    logic                w_accept;
    logic                w_nq_bad;
    logic                w_last_nq;
    logic                w_last_col;
    logic                w_tmr_load;
    logic [TMR_W-1:0]    w_tmr_val;
    logic                w_tmr_tc;

    phase_timer #(.W(TMR_W)) u_phase_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tmr_tc)
    );

    assign w_nq_bad   = (i_nq == '0) || (i_nq > NQ_W'(1 << ADDR_W));
    assign w_last_nq  = (r_idx == IDX_W'(r_nq) - IDX_W'(1));
    assign w_last_col = (r_idx == IDX_W'(COL - 1));
    assign o_in_ready = (r_state == ST_QWR) || (r_state == ST_KWR);

    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        w_idx_nx   = r_idx;
        w_inst     = '0;
        w_mem_in   = r_mem_in;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_accept   = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;

        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (i_start) begin
                    if (w_nq_bad) begin
                        w_err = 1'b1;
                    end else begin
                        w_accept   = 1'b1;
                        w_state_nx = ST_QWR;
                        w_idx_nx   = '0;
                    end
                end
            end
            ST_QWR: begin
                if (i_in_valid) begin
                    w_inst[B_QMEM_WR]                     = 1'b1;
                    w_inst[B_QKMEM_ADD +: ADD_FIELD_W]    = ADD_FIELD_W'(r_idx);
                    w_mem_in                              = i_in_data;
                    w_idx_nx                              = r_idx + IDX_W'(1);
                    if (w_last_nq) begin
                        w_state_nx = ST_KWR;
                        w_idx_nx   = '0;
                    end
                end
            end
            ST_KWR: begin
                if (i_in_valid) begin
                    w_inst[B_KMEM_WR]                     = 1'b1;
                    w_inst[B_QKMEM_ADD +: ADD_FIELD_W]    = ADD_FIELD_W'(r_idx);
                    w_mem_in                              = i_in_data;
                    w_idx_nx                              = r_idx + IDX_W'(1);
                    if (w_last_col) begin
                        w_state_nx = ST_GAP;
                        w_idx_nx   = '0;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = TMR_W'(GAP_CYC - 1);
                    end
                end
            end
            ST_GAP: begin
                if (w_tmr_tc) begin
                    w_state_nx = ST_LOAD;
                    w_idx_nx   = '0;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TMR_W'(COL + 1);
                end
            end
            ST_LOAD: begin
                // first and last load cycles carry no kmem read
                w_inst[B_LOAD] = 1'b1;
                if ((r_idx != '0) && (r_idx <= IDX_W'(COL))) begin
                    w_inst[B_KMEM_RD]                  = 1'b1;
                    w_inst[B_QKMEM_ADD +: ADD_FIELD_W] = ADD_FIELD_W'(r_idx - IDX_W'(1));
                end
                w_idx_nx = r_idx + IDX_W'(1);
                if (w_tmr_tc) begin
                    w_state_nx = ST_SETTLE1;
                    w_idx_nx   = '0;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TMR_W'(SETTLE_CYC - 1);
                end
            end
            ST_SETTLE1: begin
                if (w_tmr_tc) begin
                    w_state_nx = ST_EXEC;
                    w_idx_nx   = '0;
                end
            end
            ST_EXEC: begin
                w_inst[B_EXECUTE]                  = 1'b1;
                w_inst[B_QMEM_RD]                  = 1'b1;
                w_inst[B_QKMEM_ADD +: ADD_FIELD_W] = ADD_FIELD_W'(r_idx);
                w_idx_nx                           = r_idx + IDX_W'(1);
                if (w_last_nq) begin
                    w_state_nx = ST_SETTLE2;
                    w_idx_nx   = '0;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TMR_W'(SETTLE_CYC - 1);
                end
            end
            ST_SETTLE2: begin
                if (w_tmr_tc) begin
                    w_state_nx = ST_OFIFO;
                    w_idx_nx   = '0;
                end
            end
            ST_OFIFO: begin
                w_inst[B_OFIFO_RD]                = 1'b1;
                w_inst[B_PMEM_WR]                 = 1'b1;
                w_inst[B_PMEM_ADD +: ADD_FIELD_W] = ADD_FIELD_W'(r_idx);
                w_idx_nx                          = r_idx + IDX_W'(1);
                if (w_last_nq) begin
                    w_idx_nx   = '0;
                    w_step_nx  = NS_ACC;
                    w_state_nx = r_norm_en ? ST_NORM : ST_DONE;
                end
            end
            ST_NORM: begin
                w_inst[B_PMEM_ADD +: ADD_FIELD_W] = ADD_FIELD_W'(r_idx);
                case (r_step)
                    NS_ACC: begin
                        w_inst[B_PMEM_RD] = 1'b1;
                        w_inst[B_ACC]     = 1'b1;
                        w_step_nx         = NS_WAIT;
                    end
                    NS_WAIT: w_step_nx = NS_DIV;
                    NS_DIV: begin
                        w_inst[B_DIV] = 1'b1;
                        w_step_nx     = NS_WB;
                    end
                    default: begin
                        w_inst[B_SFP_PMEM_WR] = 1'b1;
                        w_step_nx             = NS_ACC;
                        w_idx_nx              = r_idx + IDX_W'(1);
                        if (w_last_nq) begin
                            w_state_nx = ST_DONE;
                            w_idx_nx   = '0;
                        end
                    end
                endcase
            end
            ST_DONE: begin
                w_busy     = 1'b0;
                w_done     = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_busy     = 1'b0;
                w_state_nx = ST_IDLE;
            end
        endcase

        // abort wins over any beat or phase step taken this cycle
        if (i_abort && (r_state != ST_IDLE)) begin
            w_state_nx = ST_IDLE;
            w_idx_nx   = '0;
            w_step_nx  = NS_ACC;
            w_inst     = '0;
            w_mem_in   = '0;
            w_busy     = 1'b0;
            w_done     = 1'b0;
            w_tmr_load = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_step    <= NS_ACC;
            r_idx     <= '0;
            r_nq      <= '0;
            r_norm_en <= 1'b0;
            r_inst    <= '0;
            r_mem_in  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_step   <= w_step_nx;
            r_idx    <= w_idx_nx;
            r_inst   <= w_inst;
            r_mem_in <= w_mem_in;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_err    <= w_err;
            if (w_accept) begin
                r_nq      <= i_nq;
                r_norm_en <= i_norm_en;
            end
        end
    end

    assign o_inst   = r_inst;
    assign o_mem_in = r_mem_in;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_err    = r_err;

endmodule
